// File: rtl/ahb_apb_pkg.sv
// Shared encodings for the AHB-to-APB bridge front end.
//   HTRANS / HRESP encodings, slave FSM state enum, default address map
//   constants and a helper that qualifies an address phase.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [31:0] DEF_BASE      = 32'h8000_0000;
  localparam logic [31:0] DEF_SLOT_SIZE = 32'h0400_0000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BUSY = 3'd1,
    ST_DONE = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  // Address phase completes and carries a real transfer (NONSEQ or SEQ).
  function automatic logic is_active(input logic hready_in, input logic [1:0] htrans);
    return hready_in && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
  endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// Address decoder for the APB peripheral window.
//   haddr     : AHB address
//   in_map    : address lies in [BASE, BASE + NSLV*SLOT_SIZE)
//   temp_selx : one-hot slot select, 0 when unmapped
module ahb_addr_decode
  import ahb_apb_pkg::*;
#(
  parameter int unsigned       NSLV      = 3,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE      = ADDR_W'(DEF_BASE),
  parameter logic [ADDR_W-1:0] SLOT_SIZE = ADDR_W'(DEF_SLOT_SIZE)
) (
  input  logic [ADDR_W-1:0] haddr,
  output logic              in_map,
  output logic [NSLV-1:0]   temp_selx
);

  localparam int unsigned SHIFT = $clog2(SLOT_SIZE);

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] slot;

  // Slot index is compared rather than an end address so BASE near the
  // top of the address space cannot overflow the window limit.
  always_comb begin
    offset    = haddr - BASE;
    slot      = offset >> SHIFT;
    in_map    = (haddr >= BASE) && (slot < ADDR_W'(NSLV));
    temp_selx = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      temp_selx[i] = in_map && (slot == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/ahb_slave_interface_p.sv
// AHB slave front end of the AHB-to-APB bridge.
//   Decodes the address phase into one-hot peripheral selects, pipelines
//   address / write data / write control toward the APB FSM, stretches the
//   AHB data phase (hready_out low) until xfer_done and returns registered
//   read data.
//   Optional macro AHB_SLV_ERRRESP_EN: two-cycle ERROR response for
//   unmapped or oversized accesses; when undefined such transfers are
//   dropped with a zero-wait OKAY and hresp is tied to OKAY.
// Ports:
//   hclk, hresetn             : clock, synchronous active-low reset
//   hwrite, hready_in, htrans,
//   hsize, haddr, hwdata      : AHB address/data phase inputs
//   prdata, xfer_done         : APB-side read data and completion pulse
//   valid, temp_selx          : combinational accept / slot select
//   haddr_1/2, hwdata_1/2,
//   hwritereg/_1              : pipeline stages toward the APB FSM
//   hready_out, hresp, hrdata : registered AHB slave response
module ahb_slave_interface_p
  import ahb_apb_pkg::*;
#(
  parameter int unsigned       NSLV      = 3,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE      = ADDR_W'(DEF_BASE),
  parameter logic [ADDR_W-1:0] SLOT_SIZE = ADDR_W'(DEF_SLOT_SIZE)
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hwrite,
  input  logic              hready_in,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              xfer_done,
  output logic              valid,
  output logic [NSLV-1:0]   temp_selx,
  output logic [ADDR_W-1:0] haddr_1,
  output logic [ADDR_W-1:0] haddr_2,
  output logic [DATA_W-1:0] hwdata_1,
  output logic [DATA_W-1:0] hwdata_2,
  output logic              hwritereg,
  output logic              hwritereg_1,
  output logic              hready_out,
  output logic [1:0]        hresp,
  output logic [DATA_W-1:0] hrdata
);

  // Largest legal hsize: log2 of the data bus width in bytes.
  localparam int unsigned MAX_HSIZE = $clog2(DATA_W / 8);

  logic            active;
  logic            in_map;
  logic            size_ok;
  logic [NSLV-1:0] dec_sel;
  state_t          state;

  ahb_addr_decode #(
    .NSLV      (NSLV),
    .ADDR_W    (ADDR_W),
    .BASE      (BASE),
    .SLOT_SIZE (SLOT_SIZE)
  ) u_decode (
    .haddr     (haddr),
    .in_map    (in_map),
    .temp_selx (dec_sel)
  );

  // Address phase qualification.
  assign active    = is_active(hready_in, htrans);
  assign size_ok   = (hsize <= 3'(MAX_HSIZE));
  assign valid     = active && in_map && size_ok;
  // Select only asserted for a transfer that is actually forwarded.
  assign temp_selx = valid ? dec_sel : '0;

`ifdef AHB_SLV_ERRRESP_EN
  logic       err_req;
  logic [1:0] hresp_q;

  assign err_req = active && !(in_map && size_ok);
  assign hresp   = hresp_q;

  // Slave FSM: wait-state insertion, read-data capture, error response.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state      <= ST_IDLE;
      hready_out <= 1'b1;
      hresp_q    <= HRESP_OKAY;
      hrdata     <= '0;
    end else begin
      case (state)
        ST_BUSY: begin
          if (xfer_done) begin
            state      <= ST_DONE;
            hready_out <= 1'b1;
            hresp_q    <= HRESP_OKAY;
            hrdata     <= prdata;
          end
        end
        ST_ERR1: begin
          state      <= ST_ERR2;
          hready_out <= 1'b1;
          hresp_q    <= HRESP_ERROR;
        end
        // ST_IDLE, ST_DONE, ST_ERR2: ready to accept the next address phase.
        default: begin
          if (valid) begin
            state      <= ST_BUSY;
            hready_out <= 1'b0;
            hresp_q    <= HRESP_OKAY;
          end else if (err_req) begin
            state      <= ST_ERR1;
            hready_out <= 1'b0;
            hresp_q    <= HRESP_ERROR;
          end else begin
            state      <= ST_IDLE;
            hready_out <= 1'b1;
            hresp_q    <= HRESP_OKAY;
          end
        end
      endcase
    end
  end
`else
  assign hresp = HRESP_OKAY;

  // Slave FSM: wait-state insertion and read-data capture; illegal
  // transfers fall through the ready branch and are silently dropped.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state      <= ST_IDLE;
      hready_out <= 1'b1;
      hrdata     <= '0;
    end else begin
      case (state)
        ST_BUSY: begin
          if (xfer_done) begin
            state      <= ST_DONE;
            hready_out <= 1'b1;
            hrdata     <= prdata;
          end
        end
        default: begin
          if (valid) begin
            state      <= ST_BUSY;
            hready_out <= 1'b0;
          end else begin
            state      <= ST_IDLE;
            hready_out <= 1'b1;
          end
        end
      endcase
    end
  end
`endif

  // Address / data / write-control pipeline, frozen while the bus stalls.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      haddr_1     <= '0;
      haddr_2     <= '0;
      hwdata_1    <= '0;
      hwdata_2    <= '0;
      hwritereg   <= 1'b0;
      hwritereg_1 <= 1'b0;
    end else if (hready_in) begin
      haddr_1     <= haddr;
      haddr_2     <= haddr_1;
      hwdata_1    <= hwdata;
      hwdata_2    <= hwdata_1;
      hwritereg   <= hwrite;
      hwritereg_1 <= hwritereg;
    end
  end

endmodule

// File: tb/tb_ahb_slave_interface_p.sv
// Self-checking bench for ahb_slave_interface_p (NSLV=3, 32-bit bus).
module tb_ahb_slave_interface_p;
  import ahb_apb_pkg::*;

  localparam int unsigned NSLV   = 3;
  localparam int unsigned DATA_W = 32;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam logic [31:0] SLOT   = 32'h0400_0000;
`ifdef AHB_SLV_ERRRESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        hclk = 1'b0;
  logic        hresetn, hwrite, hready_in, xfer_done;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr, hwdata, prdata;
  logic        valid;
  logic [2:0]  temp_selx;
  logic [31:0] haddr_1, haddr_2, hwdata_1, hwdata_2, hrdata;
  logic        hwritereg, hwritereg_1, hready_out;
  logic [1:0]  hresp;

  ahb_slave_interface_p #(
    .NSLV(NSLV), .ADDR_W(32), .DATA_W(DATA_W), .BASE(BASE), .SLOT_SIZE(SLOT)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite), .hready_in(hready_in),
    .htrans(htrans), .hsize(hsize), .haddr(haddr), .hwdata(hwdata),
    .prdata(prdata), .xfer_done(xfer_done), .valid(valid), .temp_selx(temp_selx),
    .haddr_1(haddr_1), .haddr_2(haddr_2), .hwdata_1(hwdata_1), .hwdata_2(hwdata_2),
    .hwritereg(hwritereg), .hwritereg_1(hwritereg_1), .hready_out(hready_out),
    .hresp(hresp), .hrdata(hrdata)
  );

  always #5 hclk = ~hclk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: an outstanding-access flag, error-response phase count
  // (0 none, 1 first ERROR cycle, 2 second), last read data, and the
  // history of inputs seen on cycles where the bus advanced.
  bit          m_busy;
  int          m_err;
  logic [31:0] m_rd, m_a1, m_a2, m_d1, m_d2;
  logic        m_w1, m_w2;
  logic        last_valid;
  logic [2:0]  last_sel;

  function automatic bit m_in_map(input logic [31:0] a);
    longint unsigned la = 64'(a);
    longint unsigned lo = 64'(BASE);
    longint unsigned hi = 64'(BASE) + 64'(NSLV) * 64'(SLOT);
    return (la >= lo) && (la < hi);
  endfunction

  function automatic bit m_size_ok(input logic [2:0] sz);
    return (32'd8 << sz) <= DATA_W;
  endfunction

  function automatic bit m_valid(input logic hr, input logic [1:0] tr,
                                 input logic [2:0] sz, input logic [31:0] a);
    return hr && tr[1] && m_in_map(a) && m_size_ok(sz);
  endfunction

  function automatic bit m_err_req(input logic hr, input logic [1:0] tr,
                                   input logic [2:0] sz, input logic [31:0] a);
    return hr && tr[1] && !(m_in_map(a) && m_size_ok(sz));
  endfunction

  function automatic logic [2:0] m_sel(input bit v, input logic [31:0] a);
    int unsigned slot;
    if (!v) return 3'b000;
    slot = (a - BASE) / SLOT;
    return 3'(32'd1 << slot);
  endfunction

  function automatic logic m_hready();
    return !m_busy && (m_err != 1);
  endfunction

  function automatic logic [1:0] m_hresp();
    return (m_err != 0) ? 2'b01 : 2'b00;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_rd = '0;
    m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0; m_w1 = 1'b0; m_w2 = 1'b0;
  endtask

  // One bus cycle, entered and left 1 time unit after a rising edge.
  task automatic cycle(input logic rst_n, input logic hr, input logic [1:0] tr,
                       input logic wr, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic xd, input logic [31:0] pd);
    bit v, e;
    chk("hready_out", 64'(hready_out), 64'(m_hready()));
    chk("hresp", 64'(hresp), 64'(m_hresp()));
    chk("hrdata", 64'(hrdata), 64'(m_rd));
    chk("haddr_1", 64'(haddr_1), 64'(m_a1));
    chk("haddr_2", 64'(haddr_2), 64'(m_a2));
    chk("hwdata_1", 64'(hwdata_1), 64'(m_d1));
    chk("hwdata_2", 64'(hwdata_2), 64'(m_d2));
    chk("hwritereg", 64'(hwritereg), 64'(m_w1));
    chk("hwritereg_1", 64'(hwritereg_1), 64'(m_w2));
    hresetn = rst_n; hready_in = hr; htrans = tr; hwrite = wr; hsize = sz;
    haddr = a; hwdata = wd; xfer_done = xd; prdata = pd;
    #1;
    v = m_valid(hr, tr, sz, a);
    e = m_err_req(hr, tr, sz, a);
    last_valid = valid;
    last_sel   = temp_selx;
    chk("valid", 64'(valid), 64'(v));
    chk("temp_selx", 64'(temp_selx), 64'(m_sel(v, a)));
    @(posedge hclk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (hr) begin
        m_a2 = m_a1; m_a1 = a; m_d2 = m_d1; m_d1 = wd; m_w2 = m_w1; m_w1 = wr;
      end
      if (m_busy) begin
        if (xd) begin m_busy = 0; m_rd = pd; end
      end else if (m_err == 1) begin
        m_err = 2;
      end else begin
        m_err = 0;
        if (v) m_busy = 1;
        else if (ERR_EN && e) m_err = 1;
      end
    end
    #1;
  endtask

  task automatic idle_cycle(input logic xd, input logic [31:0] pd);
    cycle(1'b1, m_hready(), HTRANS_IDLE, 1'b0, 3'd0, 32'h0, 32'h0, xd, pd);
  endtask

  typedef struct {
    logic [1:0]  tr;
    logic [2:0]  sz;
    logic [31:0] a;
    logic        exp_v;
    logic [2:0]  exp_sel;
    logic        exp_err;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, end of test required earlier", $time);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{HTRANS_NONSEQ, 3'd2, 32'h8400_0010, 1'b1, 3'b010, 1'b0};
    tbl[1] = '{HTRANS_SEQ,    3'd0, 32'h8000_0000, 1'b1, 3'b001, 1'b0};
    tbl[2] = '{HTRANS_NONSEQ, 3'd2, 32'h8BFF_FFFC, 1'b1, 3'b100, 1'b0};
    tbl[3] = '{HTRANS_NONSEQ, 3'd2, 32'h8C00_0000, 1'b0, 3'b000, 1'b1};
    tbl[4] = '{HTRANS_NONSEQ, 3'd2, 32'h7FFF_FFFC, 1'b0, 3'b000, 1'b1};
    tbl[5] = '{HTRANS_NONSEQ, 3'd3, 32'h8000_0000, 1'b0, 3'b000, 1'b1};
    tbl[6] = '{HTRANS_BUSY,   3'd2, 32'h8400_0000, 1'b0, 3'b000, 1'b0};
    tbl[7] = '{HTRANS_IDLE,   3'd2, 32'h8000_0000, 1'b0, 3'b000, 1'b0};
    tbl[8] = '{HTRANS_NONSEQ, 3'd1, 32'h8800_0002, 1'b1, 3'b100, 1'b0};

    // Power-up reset.
    hresetn = 1'b0; hready_in = 1'b1; htrans = HTRANS_IDLE; hwrite = 1'b0;
    hsize = 3'd0; haddr = '0; hwdata = '0; xfer_done = 1'b0; prdata = '0;
    model_reset();
    repeat (2) @(posedge hclk);
    #1;
    cycle(1'b0, 1'b1, HTRANS_NONSEQ, 1'b1, 3'd2, 32'h8000_0000, 32'h55, 1'b0, 32'h0);
    chk("rst_hready_out", 64'(hready_out), 64'd1);
    chk("rst_hresp", 64'(hresp), 64'd0);
    chk("rst_hrdata", 64'(hrdata), 64'd0);
    chk("rst_haddr_1", 64'(haddr_1), 64'd0);
    idle_cycle(1'b0, 32'h0);
    idle_cycle(1'b0, 32'h0);

    // Decode table, each vector launched from an idle bus.
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, 1'b1, tbl[i].tr, 1'b0, tbl[i].sz, tbl[i].a, 32'h0, 1'b0, 32'h0);
      chk("tbl_valid", 64'(last_valid), 64'(tbl[i].exp_v));
      chk("tbl_sel", 64'(last_sel), 64'(tbl[i].exp_sel));
      chk("tbl_next_hready", 64'(hready_out),
          64'(!(tbl[i].exp_v || (tbl[i].exp_err && ERR_EN))));
      chk("tbl_next_hresp", 64'(hresp), 64'((tbl[i].exp_err && ERR_EN) ? 2'b01 : 2'b00));
      idle_cycle(1'b1, 32'h1000 + 32'(i));
      chk("tbl_second_hready", 64'(hready_out), 64'd1);
      chk("tbl_second_hresp", 64'(hresp), 64'((tbl[i].exp_err && ERR_EN) ? 2'b01 : 2'b00));
      idle_cycle(1'b0, 32'h0);
    end

    // Read with xfer_done three cycles after the address phase.
    cycle(1'b1, 1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h8400_0010, 32'h0, 1'b0, 32'h0);
    chk("rd_valid", 64'(last_valid), 64'd1);
    chk("rd_sel", 64'(last_sel), 64'(3'b010));
    for (int i = 0; i < 3; i++) begin
      chk("rd_wait", 64'(hready_out), 64'd0);
      cycle(1'b1, m_hready(), HTRANS_IDLE, 1'b0, 3'd0, 32'h0, 32'h0,
            (i == 2), (i == 2) ? 32'hDEAD_BEEF : 32'h0BAD_0000);
    end
    chk("rd_done_hready", 64'(hready_out), 64'd1);
    chk("rd_hrdata", 64'(hrdata), 64'(32'hDEAD_BEEF));
    idle_cycle(1'b0, 32'h0);

    // Back-to-back writes, second accepted in the completion cycle.
    cycle(1'b1, m_hready(), HTRANS_NONSEQ, 1'b1, 3'd2, 32'h8000_0000, 32'h0, 1'b0, 32'h0);
    chk("b2b_sel1", 64'(last_sel), 64'(3'b001));
    cycle(1'b1, m_hready(), HTRANS_NONSEQ, 1'b1, 3'd2, 32'h8800_0004, 32'hA5A5_0001, 1'b0, 32'h0);
    chk("b2b_haddr_1_hold", 64'(haddr_1), 64'(32'h8000_0000));
    cycle(1'b1, m_hready(), HTRANS_NONSEQ, 1'b1, 3'd2, 32'h8800_0004, 32'hA5A5_0001, 1'b1, 32'h0000_0111);
    chk("b2b_done_hready", 64'(hready_out), 64'd1);
    cycle(1'b1, m_hready(), HTRANS_NONSEQ, 1'b1, 3'd2, 32'h8800_0004, 32'hA5A5_0001, 1'b0, 32'h0);
    chk("b2b_sel2", 64'(last_sel), 64'(3'b100));
    chk("b2b_no_bubble", 64'(hready_out), 64'd0);
    chk("b2b_haddr_1", 64'(haddr_1), 64'(32'h8800_0004));
    cycle(1'b1, m_hready(), HTRANS_IDLE, 1'b0, 3'd0, 32'h0, 32'hA5A5_0002, 1'b1, 32'h0000_0222);
    idle_cycle(1'b0, 32'h0);

    // Reset while waiting; reset beats a coincident xfer_done.
    cycle(1'b1, m_hready(), HTRANS_NONSEQ, 1'b0, 3'd2, 32'h8000_0100, 32'h0, 1'b0, 32'h0);
    cycle(1'b0, m_hready(), HTRANS_IDLE, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h1234_5678);
    chk("rstbusy_hready", 64'(hready_out), 64'd1);
    chk("rstbusy_hrdata", 64'(hrdata), 64'd0);
    idle_cycle(1'b1, 32'hCAFE_F00D);
    chk("late_done_hready", 64'(hready_out), 64'd1);
    chk("late_done_hrdata", 64'(hrdata), 64'd0);
    idle_cycle(1'b0, 32'h0);

    // Randomised traffic against the model.
    for (int n = 0; n < 500; n++) begin
      logic        r_rst, r_hr, r_wr, r_xd;
      logic [1:0]  r_tr;
      logic [2:0]  r_sz;
      logic [31:0] r_a;
      r_rst = ($urandom_range(0, 59) != 0);
      r_hr  = ($urandom_range(0, 4) == 0) ? 1'($urandom_range(0, 1)) : m_hready();
      r_tr  = 2'($urandom_range(0, 3));
      r_wr  = 1'($urandom_range(0, 1));
      r_sz  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0:       r_a = 32'h7C00_0000 + 32'($urandom_range(0, 32'h13FF_FFFF));
        1:       r_a = BASE + SLOT * 32'($urandom_range(0, 3)) - 32'($urandom_range(0, 1)) * 32'h4;
        default: r_a = BASE + 32'($urandom_range(0, 32'h0BFF_FFFF));
      endcase
      r_xd  = ($urandom_range(0, 2) == 0);
      cycle(r_rst, r_hr, r_tr, r_wr, r_sz, r_a, $urandom, r_xd, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_slave_interface_p.md
# ahb_slave_interface_p

Parametrised next-generation AHB slave front end for the AHB-to-APB bridge. Decodes the AHB address phase into NSLV one-hot peripheral selects and pipelines address, data and write control toward the APB-side FSM. Inserts AHB wait states (`hready_out` low) until the APB side reports completion, and returns registered read data. Optionally generates the two-cycle AHB ERROR response for unmapped or oversized accesses.

## Interface
- `NSLV`, 3: number of APB peripheral slots; 1..8.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; 32 or 64.
- `BASE`, 32'h8000_0000: base address of slot 0.
- `SLOT_SIZE`, 32'h0400_0000: bytes per slot; power of two.
- `hclk` in 1: clock; all logic on rising edge.
- `hresetn` in 1: synchronous reset, active-low.
- `hwrite` in 1: AHB write/read.
- `hready_in` in 1: bus-level HREADY; address phase completes when 1.
- `htrans` in 2: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `hsize` in 3: transfer size, log2 bytes.
- `haddr` in ADDR_W: address.
- `hwdata` in DATA_W: write data.
- `prdata` in DATA_W: APB read data, valid with `xfer_done`.
- `xfer_done` in 1: one-cycle pulse from APB FSM, access complete.
- `valid` out 1: accepted, mapped, legal transfer in current address phase (combinational).
- `temp_selx` out NSLV: one-hot slot select (combinational); 0 if unmapped.
- `haddr_1`, `haddr_2` out ADDR_W: address pipeline stages.
- `hwdata_1`, `hwdata_2` out DATA_W: write-data pipeline stages.
- `hwritereg`, `hwritereg_1` out 1: write-control pipeline stages.
- `hready_out` out 1: slave HREADY.
- `hresp` out 2: OKAY=00, ERROR=01.
- `hrdata` out DATA_W: registered read data.

## Operation
- `active` = `hready_in` & `htrans[1]` (NONSEQ or SEQ); BUSY/IDLE never active.
- `in_map` = `haddr` >= BASE and `haddr` < BASE+NSLV*SLOT_SIZE; slot = (`haddr`-BASE)>>log2(SLOT_SIZE).
- `size_ok` = 8<<`hsize` <= DATA_W.
- `valid` = `active` & `in_map` & `size_ok`; `err_req` = `active` & !(`in_map` & `size_ok`).
- Pipeline registers advance only when `hready_in`=1 and hold otherwise. All reset to 0.
- FSM states:
  - ST_IDLE: `hready_out`=1, OKAY.
  - ST_BUSY: `hready_out`=0; on `xfer_done`, capture `prdata` into `hrdata` and go to ST_DONE.
  - ST_DONE: `hready_out`=1, OKAY.
  - ST_ERR1: `hready_out`=0, ERROR.
  - ST_ERR2: `hready_out`=1, ERROR.
- Transitions:
  - From ST_IDLE, ST_DONE and ST_ERR2: `valid` -> ST_BUSY; `err_req` -> ST_ERR1; else ST_IDLE.
  - ST_ERR1 -> ST_ERR2 unconditionally.
  - ST_BUSY holds until `xfer_done`.
- `xfer_done` outside ST_BUSY is ignored.
- `hrdata` holds its value outside capture.
- Writes also complete through ST_DONE; `hrdata` is still updated from `prdata`, and masters ignore it.

## Timing
- Reset: state ST_IDLE, `hready_out`=1, `hresp`=00, `hrdata`=0, all pipeline registers 0.
- Combinational outputs `valid`/`temp_selx` follow their inputs during reset.
- Single access:
  - Address phase at cycle 0 (`valid`=1).
  - ST_BUSY from cycle 1; `hready_out`=0 until the cycle after `xfer_done`.
  - `xfer_done` at cycle k gives ST_DONE at k+1: `hready_out`=1, `hrdata`=`prdata`@k.
  - Minimum latency is 2 cycles (`xfer_done` at cycle 1).
- Back-to-back: a `valid` in the ST_DONE cycle goes directly to ST_BUSY; no idle bubble.
- Error: `err_req` at cycle 0 gives ST_ERR1 at cycle 1 (ERROR, wait) and ST_ERR2 at cycle 2 (ERROR, ready), then ST_IDLE or the next transfer.
- Reset mid-transfer: returns to ST_IDLE next edge. The outstanding APB access is abandoned, and a later `xfer_done` is ignored.
- Simultaneous `xfer_done` and `hresetn`=0: reset wins.

## Configuration
- `AHB_SLV_ERRRESP_EN` defined: ST_ERR1/ST_ERR2 exist and behave as above.
- `AHB_SLV_ERRRESP_EN` undefined:
  - `err_req` is ignored; the transfer is dropped with zero-wait OKAY and the FSM stays in its ready state.
  - `hresp` is tied to 00 and the ERROR states are not built.
  - `valid` and `temp_selx` are still 0 for the dropped transfer.

## Structure
- Package `ahb_apb_pkg`: HTRANS and HRESP encodings, FSM state enum, default BASE/SLOT_SIZE constants.
- Sub-module `ahb_addr_decode`, parametrised on NSLV/ADDR_W/BASE/SLOT_SIZE: outputs `in_map` and `temp_selx`.
- FSM, pipeline registers and `hrdata` capture live in the top module.

## Test plan
- Reset, then idle bus: `hready_out`=1, `hresp`=00, `hrdata`=0, all pipeline registers 0.
- NONSEQ read 0x8400_0010, `hsize`=2, `xfer_done` 3 cycles later with `prdata`=0xDEAD_BEEF:
  - `valid`=1, `temp_selx`=3'b010.
  - `hready_out` low 3 cycles, then high with `hrdata`=0xDEAD_BEEF.
- Back-to-back writes 0x8000_0000 then 0x8800_0004, second presented in the ST_DONE cycle:
  - `temp_selx` 001 then 100.
  - No idle cycle between the two ST_BUSY periods; `haddr_1` holds during waits.
- Unmapped 0x8C00_0000, or `hsize`=3 with DATA_W=32:
  - With macro: ERROR for 2 cycles, `hready_out` 0 then 1.
  - Without macro: OKAY, `hready_out`=1, `valid`=0.
- `hresetn`=0 while in ST_BUSY, then `xfer_done` pulse after reset release: stays ST_IDLE, `hready_out`=1, `hrdata` unchanged at 0.
- `htrans`=BUSY with mapped address and `hready_in`=1: `valid`=0, FSM stays ST_IDLE, OKAY.
